match_controller: RTL and testbench

//   Match-level FSM for Pong; it is the producer of the winner code consumed by win_screen.
//   - Counts goals per player and sequences serve, play and win phases.
//   - Drives winner (a PLAYER_x_COLOR code from global_symbols.vh) to the win-text renderer.
//   - Drives play_en and ball_reset to the ball/paddle logic.
//   - Sits between the collision/goal detector and the display path.

---
 rtl/match_controller.sv | 158 +++++++++++++++
 tb/tb_match_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match-level sequencer for Pong: tracks goals per player and steps through serve, play and win
// phases, driving play_en, ball_reset, serve_dir and the winner colour code to the display path.
module match_controller #(
  parameter int          WIN_SCORE          = 7,
  parameter int          SCORE_W            = 4,
  parameter int          SERVE_DELAY_FRAMES = 60,
  parameter int          WIN_HOLD_FRAMES    = 300,
  parameter int          CNT_W              = 9,
  parameter logic [2:0]  PLAYER_1_COLOR     = 3'd1,
  parameter logic [2:0]  PLAYER_2_COLOR     = 3'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         winner,
  output logic               play_en,
  output logic               ball_reset,
  output logic               serve_dir
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, WIN} state_t;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0]   WIN_HOLD   = CNT_W'(WIN_HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  // Frame counter step that parks at the limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [SCORE_W-1:0] s1_inc, s2_inc;
  logic [2:0]         winner_q, winner_d;
  logic               play_en_q, play_en_d;
  logic               ball_reset_q, ball_reset_d;
  logic               dir_q, dir_d;

  assign s1_inc = s1_q + SCORE_W'(1);
  assign s2_inc = s2_q + SCORE_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    winner_d     = winner_q;
    dir_d        = dir_q;
    ball_reset_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_btn) begin
          state_d      = SERVE;
          cnt_d        = '0;
          ball_reset_d = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        // A simultaneous goal pair is treated as a replay: no score, same serve side.
        if (goal_p1 && goal_p2) begin
          state_d      = SERVE;
          cnt_d        = '0;
          ball_reset_d = 1'b1;
        end else if (goal_p1) begin
          s1_d  = s1_inc;
          dir_d = 1'b1;
          cnt_d = '0;
          if (s1_inc == WIN_VAL) begin
            state_d  = WIN;
            winner_d = PLAYER_1_COLOR;
          end else begin
            state_d      = SERVE;
            ball_reset_d = 1'b1;
          end
        end else if (goal_p2) begin
          s2_d  = s2_inc;
          dir_d = 1'b0;
          cnt_d = '0;
          if (s2_inc == WIN_VAL) begin
            state_d  = WIN;
            winner_d = PLAYER_2_COLOR;
          end else begin
            state_d      = SERVE;
            ball_reset_d = 1'b1;
          end
        end
      end
      WIN: begin
        if (start_btn && (cnt_q == WIN_HOLD)) begin
          state_d      = SERVE;
          cnt_d        = '0;
          s1_d         = '0;
          s2_d         = '0;
          winner_d     = 3'd0;
          dir_d        = 1'b0;
          ball_reset_d = 1'b1;
        end else if (frame_tick) begin
          cnt_d = sat_inc(cnt_q, WIN_HOLD);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        s1_d    = '0;
        s2_d    = '0;
      end
    endcase
    play_en_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      winner_q     <= 3'd0;
      play_en_q    <= 1'b0;
      ball_reset_q <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      winner_q     <= winner_d;
      play_en_q    <= play_en_d;
      ball_reset_q <= ball_reset_d;
      dir_q        <= dir_d;
    end
  end

  assign score_p1   = s1_q;
  assign score_p2   = s2_q;
  assign winner     = winner_q;
  assign play_en    = play_en_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = dir_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: vector tables plus hand sequences for serve delay, win hold,
// simultaneous goals and asynchronous reset, with expectations queued and checked a cycle later.
module tb_match_controller;

  localparam logic [2:0] P1C = 3'd1;
  localparam logic [2:0] P2C = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start_btn = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic [2:0] winner;
  logic       play_en, ball_reset, serve_dir;

  match_controller #(
    .WIN_SCORE(7), .SCORE_W(4), .SERVE_DELAY_FRAMES(60), .WIN_HOLD_FRAMES(300), .CNT_W(9),
    .PLAYER_1_COLOR(P1C), .PLAYER_2_COLOR(P2C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .play_en(play_en), .ball_reset(ball_reset), .serve_dir(serve_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       st, g1, g2, tk;
    logic [3:0] e1, e2;
    logic [2:0] ew;
    logic       epe, ebr, edir;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] e1, e2;
    logic [2:0] ew;
    logic       epe, ebr, edir;
  } exp_t;

  vec_t tbl_idle[$];
  vec_t tbl_play[$];
  vec_t tbl_win[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, logic st, logic g1, logic g2, logic tk,
                              logic [3:0] e1, logic [3:0] e2, logic [2:0] ew,
                              logic epe, logic ebr, logic edir);
    vec_t v;
    v.nm = nm; v.st = st; v.g1 = g1; v.g2 = g2; v.tk = tk;
    v.e1 = e1; v.e2 = e2; v.ew = ew; v.epe = epe; v.ebr = ebr; v.edir = edir;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    e.nm = v.nm; e.e1 = v.e1; e.e2 = v.e2; e.ew = v.ew;
    e.epe = v.epe; e.ebr = v.ebr; e.edir = v.edir;
    sb.push_back(e);
    start_btn = v.st; goal_p1 = v.g1; goal_p2 = v.g2; frame_tick = v.tk;
    @(posedge clk);
    #1;
    start_btn = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0; frame_tick = 1'b0;
    got = sb.pop_front();
    n_checks++;
    if (score_p1 !== got.e1 || score_p2 !== got.e2 || winner !== got.ew ||
        play_en !== got.epe || ball_reset !== got.ebr || serve_dir !== got.edir) begin
      n_err++;
      $display("FAIL %s: got s1=%0d s2=%0d win=%0d pe=%0b br=%0b dir=%0b want s1=%0d s2=%0d win=%0d pe=%0b br=%0b dir=%0b",
               got.nm, score_p1, score_p2, winner, play_en, ball_reset, serve_dir,
               got.e1, got.e2, got.ew, got.epe, got.ebr, got.edir);
    end
  endtask

  task automatic step(input string nm, input logic st, input logic g1, input logic g2,
                      input logic tk, input logic [3:0] e1, input logic [3:0] e2,
                      input logic [2:0] ew, input logic epe, input logic ebr, input logic edir);
    run_vec(mk(nm, st, g1, g2, tk, e1, e2, ew, epe, ebr, edir));
  endtask

  // 59 ticks hold the ball; the 60th releases play.
  task automatic serve(input logic [3:0] e1, input logic [3:0] e2, input logic edir);
    for (int i = 0; i < 59; i++) step("serve_hold", 0, 0, 0, 1, e1, e2, 3'd0, 0, 0, edir);
    step("serve_release", 0, 0, 0, 1, e1, e2, 3'd0, 1, 0, edir);
  endtask

  task automatic win_ticks(input int n);
    for (int i = 0; i < n; i++) step("win_tick", 0, 0, 0, 1, 4'd2, 4'd7, P2C, 0, 0, 0);
  endtask

  task automatic check_zero(input string nm);
    n_checks++;
    if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || winner !== 3'd0 ||
        play_en !== 1'b0 || ball_reset !== 1'b0 || serve_dir !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got s1=%0d s2=%0d win=%0d pe=%0b br=%0b dir=%0b want all zero",
               nm, score_p1, score_p2, winner, play_en, ball_reset, serve_dir);
    end
  endtask

  initial begin
    tbl_idle.push_back(mk("idle_quiet",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl_idle.push_back(mk("idle_goal1_ign",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl_idle.push_back(mk("idle_goal2_ign",  0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl_idle.push_back(mk("idle_start",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl_idle.push_back(mk("serve_pulse_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl_idle.push_back(mk("serve_start_ign", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl_idle.push_back(mk("serve_goals_ign", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));

    tbl_play.push_back(mk("play_tick",       0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl_play.push_back(mk("play_start_ign",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl_play.push_back(mk("play_goal1",      0, 1, 0, 0, 1, 0, 0, 0, 1, 1));

    tbl_win.push_back(mk("win_goal1_ign",    0, 1, 0, 0, 2, 7, P2C, 0, 0, 0));
    tbl_win.push_back(mk("win_goal2_ign",    0, 0, 1, 0, 2, 7, P2C, 0, 0, 0));
    tbl_win.push_back(mk("win_early_start",  1, 0, 0, 0, 2, 7, P2C, 0, 0, 0));
    tbl_win.push_back(mk("win_goals_tick",   0, 1, 1, 1, 2, 7, P2C, 0, 0, 0));

    #2;
    check_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl_idle.size(); i++) run_vec(tbl_idle[i]);
    serve(0, 0, 0);
    for (int i = 0; i < tbl_play.size(); i++) run_vec(tbl_play[i]);
    serve(1, 0, 1);

    step("goal1_to_2", 0, 1, 0, 0, 2, 0, 0, 0, 1, 1);
    serve(2, 0, 1);
    step("dual_goal_replay", 0, 1, 1, 0, 2, 0, 0, 0, 1, 1);
    serve(2, 0, 1);
    step("goal2_with_tick", 0, 0, 1, 1, 2, 1, 0, 0, 1, 0);
    serve(2, 1, 0);
    for (int k = 2; k <= 6; k++) begin
      step("goal2_ramp", 0, 0, 1, 0, 2, 4'(k), 0, 0, 1, 0);
      serve(2, 4'(k), 0);
    end
    step("win_p2", 0, 0, 1, 0, 2, 7, P2C, 0, 0, 0);

    // WIN hold: one tick in the table, then start at 100 and 299 must be ignored.
    for (int i = 0; i < tbl_win.size(); i++) run_vec(tbl_win[i]);
    win_ticks(99);
    step("win_start_at_100", 1, 0, 0, 0, 2, 7, P2C, 0, 0, 0);
    win_ticks(199);
    step("win_start_at_299", 1, 0, 0, 0, 2, 7, P2C, 0, 0, 0);
    win_ticks(6);
    step("win_restart", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    serve(0, 0, 0);

    // Build 3:5 then drop reset partway through the following serve.
    for (int k = 1; k <= 3; k++) begin
      step("p1_build", 0, 1, 0, 0, 4'(k), 0, 0, 0, 1, 1);
      serve(4'(k), 0, 1);
    end
    for (int k = 1; k <= 5; k++) begin
      step("p2_build", 0, 0, 1, 0, 3, 4'(k), 0, 0, 1, 0);
      if (k < 5) serve(3, 4'(k), 0);
    end
    for (int i = 0; i < 20; i++) step("serve_3_5", 0, 0, 0, 1, 3, 5, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_serve");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 62; i++) step("idle_after_reset", 0, i[0], 0, 1, 0, 0, 0, 0, 0, 0);
    step("resume_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    serve(0, 0, 0);

    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
